// File: rtl/bip_uart_loader_pkg.sv
// Shared types and defaults for the BIP UART program loader.
// Frame on the wire: COUNT | {LO,HI} x COUNT | CHK, where CHK is the XOR of COUNT and every data byte.
package bip_uart_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_CHK  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_e;

    localparam int N_BIT_DEF   = 8;
    localparam int WORD_W_DEF  = 16;
    localparam int ADDR_W_DEF  = 11;
    localparam int TIMEOUT_DEF = 1000000;

    // States in which a frame is open and the inter-byte timer runs.
    function automatic logic in_frame(state_e s);
        return (s == ST_LO) || (s == ST_HI) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/bip_uart_loader_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// EXPIRED on the cycle the count reaches TIMEOUT-1.
module bip_timeout_counter
    import bip_uart_loader_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic CLK,
    input  logic RESET,
    input  logic CLR,
    input  logic EN,
    output logic EXPIRED
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] timer_q;
    logic [CW-1:0] timer_d;

    assign EXPIRED = (timer_q == CW'(TIMEOUT - 1));

    // Saturates at the expiry value so a stuck enable cannot wrap back to zero.
    always_comb begin
        timer_d = timer_q;
        if (CLR) begin
            timer_d = '0;
        end else if (EN && !EXPIRED) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/bip_uart_loader.sv
// Loads BIP program memory from a UART byte stream, holding the CPU for the
// duration of a frame and reporting checksum or timeout failures.
module bip_uart_loader
    import bip_uart_loader_pkg::*;
#(
    parameter int N_BIT   = N_BIT_DEF,
    parameter int WORD_W  = WORD_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              RX_DONE,
    input  logic [N_BIT-1:0]  RX_DATA,
    output logic              PM_WE,
    output logic [ADDR_W-1:0] PM_ADDR,
    output logic [WORD_W-1:0] PM_DATA,
    output logic              CPU_HOLD,
    output logic              LOAD_DONE,
    output logic              LOAD_ERR,
    output logic [2:0]        STATE
);

    state_e            state_q,   state_d;
    logic [N_BIT-1:0]  count_q,   count_d;
    logic [N_BIT-1:0]  chk_q,     chk_d;
    logic [N_BIT-1:0]  lo_q,      lo_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic              pm_we_q,   pm_we_d;
    logic [ADDR_W-1:0] pm_addr_q, pm_addr_d;
    logic [WORD_W-1:0] pm_data_q, pm_data_d;
    logic              hold_q,    hold_d;
    logic              done_q,    done_d;
    logic              err_q,     err_d;

    logic timer_clr;
    logic timer_en;
    logic timer_expired;

    // The timer restarts on every byte and whenever no frame is open, which
    // also covers the entry into LO.
    assign timer_en  = in_frame(state_q);
    assign timer_clr = RX_DONE || !timer_en;

    bip_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .CLK     (CLK),
        .RESET   (RESET),
        .CLR     (timer_clr),
        .EN      (timer_en),
        .EXPIRED (timer_expired)
    );

    assign PM_WE     = pm_we_q;
    assign PM_ADDR   = pm_addr_q;
    assign PM_DATA   = pm_data_q;
    assign CPU_HOLD  = hold_q;
    assign LOAD_DONE = done_q;
    assign LOAD_ERR  = err_q;
    assign STATE     = state_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        chk_d     = chk_q;
        lo_d      = lo_q;
        addr_d    = addr_q;
        pm_we_d   = 1'b0;
        pm_addr_d = pm_addr_q;
        pm_data_d = pm_data_q;
        hold_d    = hold_q;
        done_d    = 1'b0;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                if (RX_DONE && (RX_DATA != '0)) begin
                    count_d = RX_DATA;
                    chk_d   = RX_DATA;
                    addr_d  = '0;
                    err_d   = 1'b0;
                    hold_d  = 1'b1;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (RX_DONE) begin
                    lo_d    = RX_DATA;
                    chk_d   = chk_q ^ RX_DATA;
                    state_d = ST_HI;
                end else if (timer_expired) begin
                    err_d   = 1'b1;
                    hold_d  = 1'b0;
                    state_d = ST_ERR;
                end
            end
            ST_HI: begin
                if (RX_DONE) begin
                    pm_we_d   = 1'b1;
                    pm_addr_d = addr_q;
                    pm_data_d = {RX_DATA, lo_q};
                    addr_d    = addr_q + 1'b1;
                    chk_d     = chk_q ^ RX_DATA;
                    count_d   = count_q - 1'b1;
                    state_d   = (count_q == N_BIT'(1)) ? ST_CHK : ST_LO;
                end else if (timer_expired) begin
                    err_d   = 1'b1;
                    hold_d  = 1'b0;
                    state_d = ST_ERR;
                end
            end
            ST_CHK: begin
                if (RX_DONE) begin
                    hold_d = 1'b0;
                    if (RX_DATA == chk_q) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end
                end else if (timer_expired) begin
                    err_d   = 1'b1;
                    hold_d  = 1'b0;
                    state_d = ST_ERR;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: begin
                hold_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            chk_q     <= '0;
            lo_q      <= '0;
            addr_q    <= '0;
            pm_we_q   <= 1'b0;
            pm_addr_q <= '0;
            pm_data_q <= '0;
            hold_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            chk_q     <= chk_d;
            lo_q      <= lo_d;
            addr_q    <= addr_d;
            pm_we_q   <= pm_we_d;
            pm_addr_q <= pm_addr_d;
            pm_data_q <= pm_data_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_bip_uart_loader.sv
// Directed bench for bip_uart_loader: good frames, bad checksum, zero COUNT,
// inter-byte timeout and mid-frame reset, with hand-computed expectations.
module tb_bip_uart_loader;

    localparam int N_BIT   = 8;
    localparam int WORD_W  = 16;
    localparam int ADDR_W  = 11;
    localparam int TIMEOUT = 100;

    logic              CLK;
    logic              RESET;
    logic              RX_DONE;
    logic [N_BIT-1:0]  RX_DATA;
    logic              PM_WE;
    logic [ADDR_W-1:0] PM_ADDR;
    logic [WORD_W-1:0] PM_DATA;
    logic              CPU_HOLD;
    logic              LOAD_DONE;
    logic              LOAD_ERR;
    logic [2:0]        STATE;

    int cmp_cnt  = 0;
    int fail_cnt = 0;

    bip_uart_loader #(
        .N_BIT   (N_BIT),
        .WORD_W  (WORD_W),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .RX_DONE   (RX_DONE),
        .RX_DATA   (RX_DATA),
        .PM_WE     (PM_WE),
        .PM_ADDR   (PM_ADDR),
        .PM_DATA   (PM_DATA),
        .CPU_HOLD  (CPU_HOLD),
        .LOAD_DONE (LOAD_DONE),
        .LOAD_ERR  (LOAD_ERR),
        .STATE     (STATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One-cycle RX_DONE strobe; returns on the falling edge right after the
    // sampling edge, so registered reactions are already visible.
    task automatic applyStimulus(input logic [N_BIT-1:0] b);
        @(negedge CLK);
        RX_DONE = 1'b1;
        RX_DATA = b;
        @(negedge CLK);
        RX_DONE = 1'b0;
        RX_DATA = 8'h5A;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        cmp_cnt++;
        assert (observed === expected) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " state"}, 32'(STATE), 32'd0);
        checkOutput({tag, " hold"}, 32'(CPU_HOLD), 32'd0);
        checkOutput({tag, " we"}, 32'(PM_WE), 32'd0);
        checkOutput({tag, " done"}, 32'(LOAD_DONE), 32'd0);
        checkOutput({tag, " err"}, 32'(LOAD_ERR), 32'd0);
        checkOutput({tag, " addr"}, 32'(PM_ADDR), 32'd0);
        checkOutput({tag, " data"}, 32'(PM_DATA), 32'd0);
    endtask

    task automatic checkWrite(input string tag, input logic [31:0] addr, input logic [31:0] data);
        checkOutput({tag, " we"}, 32'(PM_WE), 32'd1);
        checkOutput({tag, " addr"}, 32'(PM_ADDR), addr);
        checkOutput({tag, " data"}, 32'(PM_DATA), data);
    endtask

    initial begin
        RESET   = 1'b0;
        RX_DONE = 1'b0;
        RX_DATA = '0;
        repeat (3) @(negedge CLK);
        checkIdleOutputs("reset");
        RESET = 1'b1;
        @(negedge CLK);

        $display("[TB] single-word frame");
        applyStimulus(8'h01);
        checkOutput("f1 state lo", 32'(STATE), 32'd1);
        checkOutput("f1 hold on", 32'(CPU_HOLD), 32'd1);
        applyStimulus(8'h34);
        checkOutput("f1 state hi", 32'(STATE), 32'd2);
        checkOutput("f1 no early we", 32'(PM_WE), 32'd0);
        applyStimulus(8'h12);
        checkWrite("f1 w0", 32'h0, 32'h1234);
        checkOutput("f1 state chk", 32'(STATE), 32'd3);
        @(negedge CLK);
        checkOutput("f1 we pulse", 32'(PM_WE), 32'd0);
        applyStimulus(8'h27);
        checkOutput("f1 done", 32'(LOAD_DONE), 32'd1);
        checkOutput("f1 hold off", 32'(CPU_HOLD), 32'd0);
        checkOutput("f1 state done", 32'(STATE), 32'd4);
        checkOutput("f1 err", 32'(LOAD_ERR), 32'd0);
        @(negedge CLK);
        checkOutput("f1 done pulse", 32'(LOAD_DONE), 32'd0);
        checkOutput("f1 back idle", 32'(STATE), 32'd0);

        $display("[TB] three-word frame");
        applyStimulus(8'h03);
        applyStimulus(8'hAA);
        applyStimulus(8'h01);
        checkWrite("f3 w0", 32'h0, 32'h01AA);
        checkOutput("f3 state lo", 32'(STATE), 32'd1);
        applyStimulus(8'hBB);
        checkOutput("f3 we gap", 32'(PM_WE), 32'd0);
        applyStimulus(8'h02);
        checkWrite("f3 w1", 32'h1, 32'h02BB);
        applyStimulus(8'hCC);
        applyStimulus(8'h03);
        checkWrite("f3 w2", 32'h2, 32'h03CC);
        checkOutput("f3 state chk", 32'(STATE), 32'd3);
        checkOutput("f3 hold", 32'(CPU_HOLD), 32'd1);
        applyStimulus(8'hDE);
        checkOutput("f3 done", 32'(LOAD_DONE), 32'd1);
        checkOutput("f3 hold off", 32'(CPU_HOLD), 32'd0);

        $display("[TB] bad checksum");
        applyStimulus(8'h01);
        applyStimulus(8'h34);
        applyStimulus(8'h12);
        checkWrite("bad w0", 32'h0, 32'h1234);
        applyStimulus(8'h00);
        checkOutput("bad err", 32'(LOAD_ERR), 32'd1);
        checkOutput("bad no done", 32'(LOAD_DONE), 32'd0);
        checkOutput("bad state err", 32'(STATE), 32'd5);
        checkOutput("bad hold off", 32'(CPU_HOLD), 32'd0);
        @(negedge CLK);
        checkOutput("bad idle", 32'(STATE), 32'd0);
        checkOutput("bad err level", 32'(LOAD_ERR), 32'd1);

        $display("[TB] zero count ignored");
        applyStimulus(8'h00);
        checkOutput("zero state", 32'(STATE), 32'd0);
        checkOutput("zero hold", 32'(CPU_HOLD), 32'd0);
        checkOutput("zero err kept", 32'(LOAD_ERR), 32'd1);

        $display("[TB] inter-byte timeout");
        applyStimulus(8'h01);
        checkOutput("to err cleared", 32'(LOAD_ERR), 32'd0);
        checkOutput("to hold", 32'(CPU_HOLD), 32'd1);
        applyStimulus(8'h34);
        repeat (TIMEOUT - 1) @(negedge CLK);
        checkOutput("to still hi", 32'(STATE), 32'd2);
        checkOutput("to still held", 32'(CPU_HOLD), 32'd1);
        @(negedge CLK);
        checkOutput("to state err", 32'(STATE), 32'd5);
        checkOutput("to err", 32'(LOAD_ERR), 32'd1);
        checkOutput("to hold off", 32'(CPU_HOLD), 32'd0);
        checkOutput("to no write", 32'(PM_WE), 32'd0);
        @(negedge CLK);

        $display("[TB] reset mid-frame");
        applyStimulus(8'h01);
        applyStimulus(8'h34);
        RESET = 1'b0;
        #1;
        checkIdleOutputs("midrst");
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        applyStimulus(8'h01);
        applyStimulus(8'h56);
        applyStimulus(8'h78);
        checkWrite("post w0", 32'h0, 32'h7856);
        applyStimulus(8'h2F);
        checkOutput("post done", 32'(LOAD_DONE), 32'd1);
        checkOutput("post err", 32'(LOAD_ERR), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
